// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer and IF/ID pipeline register with a RUN/HALTED control FSM.
// Define PERF_CNT_EN to add saturating predicted-taken and mispredict counters.
module fetch_pc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        predicted_taken,
  input  logic [15:0] predicted_target,
  input  logic        branch_mispredicted,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  output logic [15:0] PC_curr,
  output logic        predictor_enable,
  output logic [15:0] IF_ID_PC_curr,
  output logic [15:0] IF_ID_PC_next,
  output logic [15:0] IF_ID_predicted_target,
  output logic        IF_ID_predicted_taken,
  output logic        IF_ID_valid
`ifdef PERF_CNT_EN
  ,
  output logic [15:0] pred_taken_cnt,
  output logic [15:0] mispredict_cnt
`endif
);

  typedef enum logic {StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] if_next_q, if_next_d;
  logic [15:0] if_tgt_q, if_tgt_d;
  logic        if_taken_q, if_taken_d;
  logic        if_valid_q, if_valid_d;

  logic [15:0] pc_plus2;
  logic        in_run;
  logic        mispredict_act;
  logic        halt_act;
  logic        advance;

  // Redirect/halt only apply to a live IF/ID instruction; a flushed slot is ignored.
  always_comb begin
    pc_plus2       = pc_q + 16'd2;
    in_run         = (state_q == StRun);
    mispredict_act = in_run && if_valid_q && branch_mispredicted;
    halt_act       = in_run && if_valid_q && halt && !mispredict_act;
    advance        = in_run && !mispredict_act && !halt_act && !stall;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_next_d  = if_next_q;
    if_tgt_d   = if_tgt_q;
    if_taken_d = if_taken_q;
    if_valid_d = if_valid_q;

    if (mispredict_act) begin
      pc_d       = actual_taken ? actual_target : if_next_q;
      if_valid_d = 1'b0;
      if_taken_d = 1'b0;
    end else if (halt_act) begin
      if_valid_d = 1'b0;
      state_d    = StHalted;
    end else if (advance) begin
      pc_d       = predicted_taken ? predicted_target : pc_plus2;
      if_pc_d    = pc_q;
      if_next_d  = pc_plus2;
      if_tgt_d   = predicted_target;
      if_taken_d = predicted_taken;
      if_valid_d = 1'b1;
    end
  end

  // A mispredict must retrain the predictor even while ID is stalling or halting.
  always_comb begin
    predictor_enable = mispredict_act || (in_run && !stall && !halt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      pc_q       <= 16'h0000;
      if_pc_q    <= 16'h0000;
      if_next_q  <= 16'h0000;
      if_tgt_q   <= 16'h0000;
      if_taken_q <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_next_q  <= if_next_d;
      if_tgt_q   <= if_tgt_d;
      if_taken_q <= if_taken_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign PC_curr                = pc_q;
  assign IF_ID_PC_curr          = if_pc_q;
  assign IF_ID_PC_next          = if_next_q;
  assign IF_ID_predicted_target = if_tgt_q;
  assign IF_ID_predicted_taken  = if_taken_q;
  assign IF_ID_valid            = if_valid_q;

`ifdef PERF_CNT_EN
  logic [15:0] pred_cnt_q, pred_cnt_d;
  logic [15:0] misp_cnt_q, misp_cnt_d;

  always_comb begin
    pred_cnt_d = pred_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (advance && predicted_taken && (pred_cnt_q != 16'hFFFF)) begin
      pred_cnt_d = pred_cnt_q + 16'd1;
    end
    if (mispredict_act && (misp_cnt_q != 16'hFFFF)) begin
      misp_cnt_d = misp_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_cnt_q <= 16'h0000;
      misp_cnt_q <= 16'h0000;
    end else begin
      pred_cnt_q <= pred_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign pred_taken_cnt = pred_cnt_q;
  assign mispredict_cnt = misp_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed vector table, random run against a
// behavioural model, and counter saturation when PERF_CNT_EN is defined.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, halt, predicted_taken, branch_mispredicted, actual_taken;
  logic [15:0] predicted_target, actual_target;
  logic [15:0] pc_curr, if_pc, if_next, if_tgt;
  logic        predictor_enable, if_pt, if_valid;
`ifdef PERF_CNT_EN
  logic [15:0] pred_taken_cnt, mispredict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall                  (stall),
    .halt                   (halt),
    .predicted_taken        (predicted_taken),
    .predicted_target       (predicted_target),
    .branch_mispredicted    (branch_mispredicted),
    .actual_taken           (actual_taken),
    .actual_target          (actual_target),
    .PC_curr                (pc_curr),
    .predictor_enable       (predictor_enable),
    .IF_ID_PC_curr          (if_pc),
    .IF_ID_PC_next          (if_next),
    .IF_ID_predicted_target (if_tgt),
    .IF_ID_predicted_taken  (if_pt),
    .IF_ID_valid            (if_valid)
`ifdef PERF_CNT_EN
    ,
    .pred_taken_cnt         (pred_taken_cnt),
    .mispredict_cnt         (mispredict_cnt)
`endif
  );

  typedef struct {
    logic        rst, stall, halt, pt;
    logic [15:0] ptgt;
    logic        mp, at;
    logic [15:0] atgt;
    logic [15:0] e_pc;
    logic        e_v;
    logic [15:0] e_ifpc, e_ifn, e_iftgt;
    logic        e_ifpt, e_pe;
    logic        fld_chk, pt_chk;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mkv(logic r, logic s, logic h, logic pt, logic [15:0] ptgt,
                               logic mp, logic at, logic [15:0] atgt, logic [15:0] pc,
                               logic v, logic [15:0] ifpc, logic [15:0] ifn,
                               logic [15:0] iftgt, logic ifpt, logic pe, logic fc,
                               logic pc_chk);
    vec_t t;
    t.rst = r; t.stall = s; t.halt = h; t.pt = pt; t.ptgt = ptgt;
    t.mp = mp; t.at = at; t.atgt = atgt;
    t.e_pc = pc; t.e_v = v; t.e_ifpc = ifpc; t.e_ifn = ifn; t.e_iftgt = iftgt;
    t.e_ifpt = ifpt; t.e_pe = pe; t.fld_chk = fc; t.pt_chk = pc_chk;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic h, input logic pt,
                       input logic [15:0] ptgt, input logic mp, input logic at,
                       input logic [15:0] atgt);
    rst = r; stall = s; halt = h; predicted_taken = pt; predicted_target = ptgt;
    branch_mispredicted = mp; actual_taken = at; actual_target = atgt;
  endtask

  // Behavioural model state
  bit          m_halted;
  logic [15:0] m_pc, m_ifpc, m_ifn, m_iftgt;
  logic        m_v, m_ifpt, m_fdef, m_ptdef;
  int          m_pcnt, m_mcnt;

  task automatic model_reset();
    m_halted = 0; m_pc = 0; m_ifpc = 0; m_ifn = 0; m_iftgt = 0;
    m_v = 0; m_ifpt = 0; m_fdef = 1; m_ptdef = 1; m_pcnt = 0; m_mcnt = 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic h, input logic pt,
                            input logic [15:0] ptgt, input logic mp, input logic at,
                            input logic [15:0] atgt);
    if (r) begin
      model_reset();
    end else if (!m_halted) begin
      if (mp && m_v) begin
        m_pc = at ? atgt : m_ifn;
        m_v = 0; m_ifpt = 0; m_fdef = 0; m_ptdef = 1;
        if (m_mcnt < 65535) m_mcnt++;
      end else if (h && m_v) begin
        m_v = 0; m_halted = 1; m_fdef = 0; m_ptdef = 0;
      end else if (!s) begin
        m_ifpc = m_pc;
        m_ifn = 16'((32'(m_pc) + 2) % 65536);
        m_iftgt = ptgt; m_ifpt = pt; m_v = 1; m_fdef = 1; m_ptdef = 1;
        m_pc = pt ? ptgt : m_ifn;
        if (pt && m_pcnt < 65535) m_pcnt++;
      end
    end
  endtask

  initial begin
    tbl[0]  = mkv(1,0,0,0,16'h0000,0,0,16'h0000, 16'h0000,0,16'h0000,16'h0000,16'h0000,0,1,1,1);
    tbl[1]  = mkv(0,0,0,0,16'h0000,0,0,16'h0000, 16'h0002,1,16'h0000,16'h0002,16'h0000,0,1,1,1);
    tbl[2]  = mkv(0,0,0,0,16'h0000,0,0,16'h0000, 16'h0004,1,16'h0002,16'h0004,16'h0000,0,1,1,1);
    tbl[3]  = mkv(0,0,0,0,16'h0000,0,0,16'h0000, 16'h0006,1,16'h0004,16'h0006,16'h0000,0,1,1,1);
    tbl[4]  = mkv(0,0,0,0,16'h0000,0,0,16'h0000, 16'h0008,1,16'h0006,16'h0008,16'h0000,0,1,1,1);
    tbl[5]  = mkv(0,0,0,1,16'h0080,0,0,16'h0000, 16'h0080,1,16'h0008,16'h000A,16'h0080,1,1,1,1);
    tbl[6]  = mkv(0,1,0,1,16'h1234,1,0,16'h5555, 16'h000A,0,16'h0000,16'h0000,16'h0000,0,1,0,1);
    tbl[7]  = mkv(0,0,0,0,16'h0000,0,0,16'h0000, 16'h000C,1,16'h000A,16'h000C,16'h0000,0,1,1,1);
    tbl[8]  = mkv(0,1,0,1,16'h3333,0,0,16'h0000, 16'h000C,1,16'h000A,16'h000C,16'h0000,0,0,1,1);
    tbl[9]  = mkv(0,0,1,0,16'h0000,1,1,16'h0040, 16'h0040,0,16'h0000,16'h0000,16'h0000,0,1,0,1);
    tbl[10] = mkv(0,0,0,0,16'h0000,1,1,16'h0100, 16'h0042,1,16'h0040,16'h0042,16'h0000,0,1,1,1);
    tbl[11] = mkv(0,0,0,1,16'hFFFE,0,0,16'h0000, 16'hFFFE,1,16'h0042,16'h0044,16'hFFFE,1,1,1,1);
    tbl[12] = mkv(0,0,0,0,16'h0000,0,0,16'h0000, 16'h0000,1,16'hFFFE,16'h0000,16'h0000,0,1,1,1);
    tbl[13] = mkv(0,0,1,0,16'h0000,0,0,16'h0000, 16'h0000,0,16'h0000,16'h0000,16'h0000,0,0,0,0);
    tbl[14] = mkv(0,0,0,1,16'h2222,1,1,16'h7777, 16'h0000,0,16'h0000,16'h0000,16'h0000,0,0,0,0);
    tbl[15] = mkv(0,0,0,0,16'h0000,0,0,16'h0000, 16'h0000,0,16'h0000,16'h0000,16'h0000,0,0,0,0);
    tbl[16] = mkv(1,1,1,0,16'h0000,0,0,16'h0000, 16'h0000,0,16'h0000,16'h0000,16'h0000,0,0,1,1);
    tbl[17] = mkv(0,0,0,0,16'h0000,0,0,16'h0000, 16'h0002,1,16'h0000,16'h0002,16'h0000,0,1,1,1);
    tbl[18] = mkv(0,1,1,0,16'h0000,0,0,16'h0000, 16'h0002,0,16'h0000,16'h0000,16'h0000,0,0,0,0);
    tbl[19] = mkv(1,0,0,0,16'h0000,0,0,16'h0000, 16'h0000,0,16'h0000,16'h0000,16'h0000,0,0,1,1);
    tbl[20] = mkv(0,0,1,0,16'h0000,0,0,16'h0000, 16'h0002,1,16'h0000,16'h0002,16'h0000,0,0,1,1);
    tbl[21] = mkv(0,0,0,1,16'h0010,0,0,16'h0000, 16'h0010,1,16'h0002,16'h0004,16'h0010,1,1,1,1);

    // Initial reset so the FSM state is known before the table starts.
    drive(1,0,0,0,16'h0,0,0,16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].halt, tbl[i].pt, tbl[i].ptgt,
            tbl[i].mp, tbl[i].at, tbl[i].atgt);
      #1;
      chk($sformatf("row%0d predictor_enable", i), 16'(predictor_enable), 16'(tbl[i].e_pe));
      @(posedge clk); #1;
      chk($sformatf("row%0d PC_curr", i), pc_curr, tbl[i].e_pc);
      chk($sformatf("row%0d IF_ID_valid", i), 16'(if_valid), 16'(tbl[i].e_v));
      if (tbl[i].fld_chk) begin
        chk($sformatf("row%0d IF_ID_PC_curr", i), if_pc, tbl[i].e_ifpc);
        chk($sformatf("row%0d IF_ID_PC_next", i), if_next, tbl[i].e_ifn);
        chk($sformatf("row%0d IF_ID_predicted_target", i), if_tgt, tbl[i].e_iftgt);
      end
      if (tbl[i].pt_chk) begin
        chk($sformatf("row%0d IF_ID_predicted_taken", i), 16'(if_pt), 16'(tbl[i].e_ifpt));
      end
    end

    // Randomized run against the behavioural model.
    drive(1,0,0,0,16'h0,0,0,16'h0);
    @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic r, s, h, pt, mp, at, exp_pe;
      logic [15:0] ptgt, atgt;
      r    = ($urandom_range(0, 59) == 0);
      h    = ($urandom_range(0, 24) == 0);
      s    = ($urandom_range(0, 3) == 0);
      pt   = ($urandom_range(0, 9) < 3);
      mp   = ($urandom_range(0, 4) == 0);
      at   = $urandom_range(0, 1) == 1;
      ptgt = 16'($urandom);
      atgt = 16'($urandom);
      drive(r, s, h, pt, ptgt, mp, at, atgt);
      exp_pe = !m_halted && ((mp && m_v) || (!s && !h));
      #1;
      chk($sformatf("rand%0d predictor_enable", c), 16'(predictor_enable), 16'(exp_pe));
      model_step(r, s, h, pt, ptgt, mp, at, atgt);
      @(posedge clk); #1;
      chk($sformatf("rand%0d PC_curr", c), pc_curr, m_pc);
      chk($sformatf("rand%0d IF_ID_valid", c), 16'(if_valid), 16'(m_v));
      if (m_fdef) begin
        chk($sformatf("rand%0d IF_ID_PC_curr", c), if_pc, m_ifpc);
        chk($sformatf("rand%0d IF_ID_PC_next", c), if_next, m_ifn);
        chk($sformatf("rand%0d IF_ID_predicted_target", c), if_tgt, m_iftgt);
      end
      if (m_ptdef) begin
        chk($sformatf("rand%0d IF_ID_predicted_taken", c), 16'(if_pt), 16'(m_ifpt));
      end
`ifdef PERF_CNT_EN
      chk($sformatf("rand%0d pred_taken_cnt", c), pred_taken_cnt, 16'(m_pcnt));
      chk($sformatf("rand%0d mispredict_cnt", c), mispredict_cnt, 16'(m_mcnt));
`endif
    end

`ifdef PERF_CNT_EN
    // Drive the predicted-taken counter to its ceiling and one step beyond.
    drive(1,0,0,0,16'h0,0,0,16'h0);
    @(posedge clk); #1;
    chk("sat reset pred_taken_cnt", pred_taken_cnt, 16'h0000);
    drive(0,0,0,1,16'h0100,0,0,16'h0);
    for (int k = 0; k < 65535; k++) begin
      @(posedge clk);
    end
    #1;
    chk("sat pred_taken_cnt at max", pred_taken_cnt, 16'hFFFF);
    @(posedge clk); #1;
    chk("sat pred_taken_cnt holds", pred_taken_cnt, 16'hFFFF);
    chk("sat mispredict_cnt idle", mispredict_cnt, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: stall  in  1  hazard stall from ID; hold PC and IF/ID.
REQ-004 SHALL have port: halt  in  1  HLT decoded in ID for the IF/ID instruction.
REQ-005 SHALL have port: predicted_taken  in  1  branch predictor taken flag for PC_curr.
REQ-006 SHALL have port: predicted_target  in  16  branch predictor target for PC_curr.
REQ-007 SHALL have port: branch_mispredicted  in  1  ID resolved IF/ID branch as mispredicted.
REQ-008 SHALL have port: actual_taken  in  1  resolved direction of IF/ID branch.
REQ-009 SHALL have port: actual_target  in  16  resolved target of IF/ID branch.
REQ-010 SHALL have port: PC_curr  out  16  fetch address to imem and predictor.
REQ-011 SHALL have port: predictor_enable  out  1  predictor update enable.
REQ-012 SHALL have ports: IF_ID_PC_curr, IF_ID_PC_next, IF_ID_predicted_target  out  16 each; IF_ID_predicted_taken, IF_ID_valid  out  1 each.
REQ-013 SHALL have, with PERF_CNT_EN only: pred_taken_cnt, mispredict_cnt  out  16 each.

Function
REQ-014 SHALL hold two-state FSM: RUN, HALTED.
REQ-015 SHALL compute PC_plus2 = PC_curr + 2, 16-bit, wrapping 0xFFFE -> 0x0000.
REQ-016 SHALL select next PC in RUN by priority: branch_mispredicted > halt > stall > predicted_taken > PC_plus2.
REQ-017 SHALL redirect on branch_mispredicted to actual_target if actual_taken else IF_ID_PC_next, regardless of stall/halt.
REQ-018 SHALL use predicted_target verbatim when predicted_taken and no higher-priority event.
REQ-019 SHALL, on normal advance, capture PC_curr, PC_plus2, predicted_taken, predicted_target into IF/ID with IF_ID_valid=1 at the same edge PC_curr updates.
REQ-020 SHALL, on branch_mispredicted, clear IF_ID_valid and IF_ID_predicted_taken next cycle (one-bubble flush); other IF/ID fields don't care.
REQ-021 SHALL, on stall without mispredict, hold PC_curr and all IF/ID registers unchanged.
REQ-022 SHALL act on halt only when IF_ID_valid=1 and no branch_mispredicted: PC_curr held, IF_ID_valid cleared, FSM -> HALTED.
REQ-023 SHALL in HALTED hold PC_curr, keep IF_ID_valid=0, ignore all inputs; exit only via rst.
REQ-024 SHALL drive predictor_enable = (state==RUN) && !stall && !halt, but 1 whenever branch_mispredicted in RUN.
REQ-025 SHALL ignore branch_mispredicted, actual_taken, actual_target when IF_ID_valid=0.

Reset
REQ-026 SHALL on rst (sampled at rising edge) set PC_curr=0x0000, all IF/ID fields=0, IF_ID_valid=0, FSM=RUN, counters=0.
REQ-027 SHALL give rst priority over every other input, including mid-halt and mid-stall.
REQ-028 SHALL fetch 0x0000 with IF_ID_valid=1 at the first edge after rst deasserts.

Configuration
REQ-029 SHALL compile performance counters only when macro PERF_CNT_EN is defined.
REQ-030 SHALL with PERF_CNT_EN increment pred_taken_cnt on each IF/ID capture with predicted_taken=1, mispredict_cnt on each acted-on branch_mispredicted; both saturate at 0xFFFF.
REQ-031 SHALL without PERF_CNT_EN omit counter ports and logic; all other behaviour identical.

Verification
REQ-032 Reset then 3 idle cycles, predicted_taken=0 -> PC_curr 0x0000,0x0002,0x0004; IF_ID_PC_next=PC+2, IF_ID_valid=1.
REQ-033 PC_curr=0x0008, predicted_taken=1, target=0x0080 -> next PC_curr=0x0080, IF_ID_PC_curr=0x0008, IF_ID_predicted_taken=1.
REQ-034 IF/ID branch at 0x0008 predicted taken, branch_mispredicted=1, actual_taken=0, stall=1 -> PC_curr=0x000A, IF_ID_valid=0, mispredict_cnt+1.
REQ-035 Mispredict with actual_taken=1, actual_target=0x0040 -> PC_curr=0x0040; following cycle IF_ID_valid=1, IF_ID_PC_curr=0x0040.
REQ-036 PC_curr=0xFFFE, no prediction -> next PC_curr=0x0000; halt with IF_ID_valid=1 -> PC frozen, IF_ID_valid=0 until rst; rst -> PC_curr=0x0000.
REQ-037 PERF_CNT_EN, pred_taken_cnt=0xFFFF, further taken prediction -> stays 0xFFFF.
